pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline.
- Consumes the hazard unit's load_hazard and branch_hazard, plus instruction- and data-memory wait handshakes.
- Drives per-register enable/flush for PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB.
- Owns multi-cycle memory-wait sequencing, a data-access timeout, and wrong-path fetch discard after a redirect during an instruction wait.

Parameters:
- DMEM_TIMEOUT, 64, cycles in DWAIT before the access is abandoned; legal range 2..65535.
- CNT_W, 16, width of the timeout counter; must satisfy 2**CNT_W > DMEM_TIMEOUT.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- load_hazard  in  1  load-use hazard from hazard unit (ID vs EXE)
- branch_hazard  in  1  taken branch/jump resolved in MEM; PC target valid this cycle
- imem_stall  in  1  instruction fetch not ready (level)
- dmem_req_mem  in  1  MEM-stage instruction is a load/store
- dmem_ack  in  1  data access complete (single-cycle pulse)
- pc_en  out  1  PC register load enable
- if_id_en, id_exe_en, exe_mem_en, mem_wb_en  out  1 each  pipeline register enables
- if_id_flush, id_exe_flush, exe_mem_flush, mem_wb_flush  out  1 each  load NOP/bubble into that register
- dmem_timeout  out  1  one-cycle pulse when a DWAIT access is abandoned
- stall_cycles  out  32  count of cycles with pc_en=0 (feature only)
- flush_events  out  32  count of branch redirects (feature only)

Behaviour:
- State register {RUN, DWAIT, IWAIT} and drop_pending flag are the only control state. Outputs are Mealy: combinational from state, flags and inputs. A flush wins over an enable on the same register.
- Reset (asynchronous, active-high): state=RUN, drop_pending=0, timeout counter=0, perf counters=0.
  - While reset is high: all *_en=0, all *_flush=1, dmem_timeout=0.
  - First cycle after release behaves as RUN with no pending state.
- RUN priority order: dmem > branch > load > imem.
  - dmem_req_mem & !dmem_ack: all enables 0, mem_wb_flush=1; go to DWAIT; counter=1.
  - dmem_req_mem & dmem_ack: normal advance, same cycle (zero-wait access).
  - branch_hazard: all enables 1; if_id_flush, id_exe_flush, exe_mem_flush = 1; pc_en=1 (load target).
    - If imem_stall is also high: set drop_pending=1 and go to IWAIT.
  - load_hazard (no branch): pc_en=0, if_id_en=0, id_exe_flush=1; EXE/MEM and MEM/WB advance. Exactly one bubble per assertion cycle.
  - imem_stall only: pc_en=0, if_id_en=0, id_exe_flush=1, downstream advances; go to IWAIT.
  - Otherwise: all enables 1, no flush.
- DWAIT:
  - Hold the full freeze; mem_wb_flush=1; counter increments each cycle.
  - On dmem_ack: full advance this cycle; go to RUN; counter=0.
  - When counter==DMEM_TIMEOUT without ack: dmem_timeout=1 for one cycle; advance as if acked; go to RUN.
  - branch_hazard and load_hazard are ignored in DWAIT; they stay asserted because the pipe is frozen.
- IWAIT:
  - Front end held: pc_en=0, if_id_en=0, id_exe_flush=1; back end advances.
  - branch_hazard in IWAIT: apply the RUN branch flush, pc_en=1, set drop_pending=1.
  - dmem_req_mem & !dmem_ack in IWAIT: go to DWAIT (full freeze); drop_pending is kept.
  - When imem_stall falls:
    - If drop_pending: if_id_flush=1 (discard wrong-path word), pc_en=0 (refetch target), clear drop_pending, go to RUN.
    - Otherwise: normal advance, go to RUN.
- Simultaneous dmem_ack and timeout expiry: treat as ack; no dmem_timeout pulse.
- Counter saturates; it never wraps within one DWAIT.

Optional Feature:
- PIPE_PERF_CNT_EN defined:
  - stall_cycles increments every non-reset cycle with pc_en=0.
  - flush_events increments on each accepted branch_hazard.
  - Both are 32-bit and wrap modulo 2**32.
- Not defined: no counter flops; stall_cycles and flush_events are tied to 0.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - enum pipe_state_e {RUN, DWAIT, IWAIT}.
  - struct stage_ctrl_t {en, flush}.
  - Constant DMEM_TIMEOUT_DEF=64.
- Sub-module dmem_wait_timer:
  - Inputs: start, clear.
  - Outputs: CNT_W counter, expire.
  - Async active-high reset.

Test Plan:
- Reset high 3 cycles, then release with idle inputs → during reset all en=0 and all flush=1; first released cycle all en=1, flush=0.
- load_hazard=1 for 1 cycle in RUN → pc_en=0, if_id_en=0, id_exe_flush=1, exe_mem_en=1; next cycle all en=1.
- dmem_req_mem=1 with dmem_ack on 4th cycle → DWAIT for 3 cycles with all en=0 and mem_wb_flush=1; ack cycle all en=1; state RUN.
- DMEM_TIMEOUT=8, never ack → dmem_timeout pulses exactly once on cycle 8 of DWAIT; back to RUN; no second pulse.
- imem_stall=1 for 5 cycles, branch_hazard pulse on 2nd stall cycle → that cycle has if_id/id_exe/exe_mem flush=1 and pc_en=1; on imem_stall fall if_id_flush=1 and pc_en=0; next cycle pc_en=1.
- branch_hazard and load_hazard in the same RUN cycle → branch flush pattern only, pc_en=1; with PIPE_PERF_CNT_EN, flush_events goes 0→1 and stall_cycles is unchanged.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and control-word constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  localparam int DMEM_TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {RUN, DWAIT, IWAIT} pipe_state_e;

  typedef struct packed {
    logic en;
    logic flush;
  } stage_ctrl_t;

  typedef struct packed {
    logic        pc_en;
    stage_ctrl_t if_id;
    stage_ctrl_t id_exe;
    stage_ctrl_t exe_mem;
    stage_ctrl_t mem_wb;
  } pipe_ctrl_t;

  // en = {pc, if_id, id_exe, exe_mem, mem_wb}, flush = {if_id, id_exe, exe_mem, mem_wb}
  function automatic pipe_ctrl_t mk_ctrl(input logic [4:0] en, input logic [3:0] flush);
    pipe_ctrl_t c;
    c.pc_en   = en[4];
    c.if_id   = '{en: en[3], flush: flush[3]};
    c.id_exe  = '{en: en[2], flush: flush[2]};
    c.exe_mem = '{en: en[1], flush: flush[1]};
    c.mem_wb  = '{en: en[0], flush: flush[0]};
    return c;
  endfunction

  localparam pipe_ctrl_t CTRL_ADV    = mk_ctrl(5'b11111, 4'b0000);
  localparam pipe_ctrl_t CTRL_FREEZE = mk_ctrl(5'b00000, 4'b0001);
  localparam pipe_ctrl_t CTRL_BRANCH = mk_ctrl(5'b11111, 4'b1110);
  localparam pipe_ctrl_t CTRL_BUBBLE = mk_ctrl(5'b00111, 4'b0100);
  localparam pipe_ctrl_t CTRL_DROP   = mk_ctrl(5'b01111, 4'b1000);
  localparam pipe_ctrl_t CTRL_RST    = mk_ctrl(5'b00000, 4'b1111);

endpackage

// File: rtl/dmem_wait_timer.sv
// Counts cycles spent waiting on a data access; saturates at DMEM_TIMEOUT and flags expiry.
module dmem_wait_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int DMEM_TIMEOUT = DMEM_TIMEOUT_DEF,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt,
  output logic             expire
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DMEM_TIMEOUT);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (start) begin
      r_cnt <= CNT_W'(1);
    end else if (r_cnt != '0 && r_cnt != LIMIT) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cnt    = r_cnt;
  assign expire = (r_cnt == LIMIT);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory waits, data timeout, wrong-path discard.
// Optional PIPE_PERF_CNT_EN adds stall-cycle and branch-redirect counters.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DMEM_TIMEOUT = DMEM_TIMEOUT_DEF,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_hazard,
  input  logic        branch_hazard,
  input  logic        imem_stall,
  input  logic        dmem_req_mem,
  input  logic        dmem_ack,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_exe_en,
  output logic        exe_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_exe_flush,
  output logic        exe_mem_flush,
  output logic        mem_wb_flush,
  output logic        dmem_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);

  pipe_state_e      r_state, w_state_nxt;
  logic             r_drop, w_drop_nxt;
  pipe_ctrl_t       w_ctrl;
  logic             w_timeout;
  logic             w_tmr_start, w_tmr_clear, w_tmr_expire, w_time_up;
  logic             w_front_end, w_branch_ok;
  logic [CNT_W-1:0] w_tmr_cnt;

  dmem_wait_timer #(
    .DMEM_TIMEOUT(DMEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .start (w_tmr_start),
    .clear (w_tmr_clear),
    .cnt   (w_tmr_cnt),
    .expire(w_tmr_expire)
  );

  // The counter is nonzero only while an access is being timed.
  assign w_time_up = w_tmr_expire && (w_tmr_cnt != '0);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_ctrl      = CTRL_ADV;
    w_state_nxt = r_state;
    w_drop_nxt  = r_drop;
    w_timeout   = 1'b0;
    w_tmr_start = 1'b0;
    w_tmr_clear = 1'b0;
    w_front_end = 1'b0;
    w_branch_ok = 1'b0;

    case (r_state)
      DWAIT: begin
        if (dmem_ack || w_time_up) begin
          w_timeout   = !dmem_ack;
          w_tmr_clear = 1'b1;
          w_front_end = 1'b1;
        end else begin
          w_ctrl = CTRL_FREEZE;
        end
      end
      default: begin
        if (dmem_req_mem && !dmem_ack) begin
          w_ctrl      = CTRL_FREEZE;
          w_state_nxt = DWAIT;
          w_tmr_start = 1'b1;
        end else begin
          w_front_end = 1'b1;
          w_branch_ok = 1'b1;
        end
      end
    endcase

    // Front-end decision shared by RUN, IWAIT and the cycle that leaves DWAIT.
    if (w_front_end) begin
      if (w_branch_ok && branch_hazard) begin
        w_ctrl      = CTRL_BRANCH;
        w_drop_nxt  = imem_stall;
        w_state_nxt = imem_stall ? IWAIT : RUN;
      end else if (imem_stall) begin
        w_ctrl      = CTRL_BUBBLE;
        w_state_nxt = IWAIT;
      end else if (r_drop) begin
        w_ctrl      = CTRL_DROP;
        w_drop_nxt  = 1'b0;
        w_state_nxt = RUN;
      end else begin
        w_ctrl      = load_hazard ? CTRL_BUBBLE : CTRL_ADV;
        w_state_nxt = RUN;
      end
    end

    if (reset) begin
      w_ctrl    = CTRL_RST;
      w_timeout = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  assign pc_en         = w_ctrl.pc_en;
  assign if_id_en      = w_ctrl.if_id.en;
  assign id_exe_en     = w_ctrl.id_exe.en;
  assign exe_mem_en    = w_ctrl.exe_mem.en;
  assign mem_wb_en     = w_ctrl.mem_wb.en;
  assign if_id_flush   = w_ctrl.if_id.flush;
  assign id_exe_flush  = w_ctrl.id_exe.flush;
  assign exe_mem_flush = w_ctrl.exe_mem.flush;
  assign mem_wb_flush  = w_ctrl.mem_wb.flush;
  assign dmem_timeout  = w_timeout;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] r_stall_cycles, r_flush_events;
  logic        w_redirect;

  assign w_redirect = (w_ctrl == CTRL_BRANCH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (!w_ctrl.pc_en) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_redirect)    r_flush_events <= r_flush_events + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule
